mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL declare parameters (name, default, meaning): none; widths fixed at XLEN=64.
REQ-002 SHALL use a single clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 mdu_info_i  input  10  decoded MDU bus; bit0 VALID, bit1 WOP, bit2 MUL, bit3 MULH, bit4 MULHSU, bit5 MULHU, bit6 DIV, bit7 DIVU, bit8 REM, bit9 REMU.
REQ-005 op1_i  input  64  rs1 value (dividend/multiplicand).
REQ-006 op2_i  input  64  rs2 value (divisor/multiplier).
REQ-007 flush_i  input  1  pipeline flush; kills the in-flight operation.
REQ-008 res_ready_i  input  1  downstream accepts the result.
REQ-009 stall_o  output  1  holds IF/ID/EX while the MDU is occupied.
REQ-010 res_valid_o  output  1  result valid.
REQ-011 res_o  output  64  result.

Function
REQ-012 SHALL implement the FSM states IDLE, CALC and DONE, with IDLE as the reset state.
REQ-013 IDLE->CALC: on a clock edge with VALID=1, flush_i=0 and a normal case, the block latches the op one-hot, WOP, the operand magnitudes, the result-sign flags and the iteration count.
REQ-014 Iteration count: 64 for non-W ops and 32 for W ops; a 7-bit counter decrements once per CALC cycle, and at 1 the FSM moves CALC->DONE.
REQ-015 W ops: operands are the low 32 bits, sign-extended for DIVW/REMW/MULW and zero-extended for DIVUW/REMUW; the final result is {32{r[31]}, r[31:0]}.
REQ-016 MUL*: shift-add over unsigned magnitudes into a 128-bit accumulator, one multiplier bit per cycle.
- MUL returns the low 64 bits; MULH/MULHSU/MULHU return the high 64 bits.
- Signedness: MULH has both operands signed, MULHSU has op1 signed and op2 unsigned, MULHU has both unsigned.
- The 128-bit product is two's-complement negated when the result sign is 1.
REQ-017 DIV*/REM*: restoring shift-subtract over magnitudes, one quotient bit per cycle.
- The quotient sign is s1 XOR s2 (signed ops only).
- The remainder sign follows the dividend.
REQ-018 Divide by zero: the block goes IDLE->DONE directly, with quotient = all ones and remainder = dividend (for W ops, the sign-extended low 32 bits).
REQ-019 Signed overflow (dividend = most negative value, divisor = -1, at the 64- or 32-bit width): the block goes IDLE->DONE directly, with quotient = dividend and remainder = 0.
REQ-020 DONE: res_valid_o=1 and res_o holds a stable result; DONE->IDLE on res_ready_i=1.
REQ-021 Latency, accept edge to res_valid_o: N+1 cycles (N = 64 or 32) for normal cases and 1 cycle for the REQ-018/REQ-019 cases.
REQ-022 stall_o (combinational) = (IDLE & VALID & ~flush_i) | CALC | (DONE & ~res_ready_i).
REQ-023 flush_i=1 in CALC or DONE forces IDLE on the next edge and drops res_valid_o; flush_i has priority over res_ready_i and over counter expiry.
REQ-024 A VALID input presented in the same cycle as the DONE->IDLE transition is not accepted; it is accepted on the following cycle, because stall_o holds it.
REQ-025 mdu_info_i, op1_i and op2_i are ignored outside IDLE; a mid-operation change to the inputs has no effect on the result.
REQ-026 An op one-hot with more than one bit set is undefined and SHALL NOT be checked.

Reset
REQ-027 Asserting rst_n=0 at any time, including mid-CALC: state=IDLE, counter=0, accumulators=0, res_valid_o=0, res_o=0, and stall_o depends only on the inputs.
REQ-028 The first accept is possible on the first rising edge after rst_n deasserts.

Verification
REQ-029 MUL, op1=7, op2=-3 -> res_valid_o after 65 cycles, res_o=0xFFFF_FFFF_FFFF_FFEB, stall_o high throughout.
REQ-030 DIVW, op1=0x0000_0000_8000_0000, op2=0xFFFF_FFFF_FFFF_FFFF -> 1-cycle latency, res_o=0xFFFF_FFFF_8000_0000; REMW with the same operands -> res_o=0.
REQ-031 DIVU, op1=100, op2=0 -> res_o=0xFFFF_FFFF_FFFF_FFFF after 1 cycle; REM, op1=-5, op2=0 -> res_o=-5.
REQ-032 REM, op1=-7, op2=2 -> res_o=-1; DIV with the same operands -> res_o=-3, latency 65.
REQ-033 MULHU, op1=op2=0xFFFF_FFFF_FFFF_FFFF with res_ready_i=0 for 5 cycles after DONE -> res_o holds 0xFFFF_FFFF_FFFF_FFFE and stall_o stays high until res_ready_i=1.
REQ-034 flush_i pulsed at CALC cycle 10, then rst_n pulsed mid-CALC on a second op -> IDLE with res_valid_o=0 each time; a following ADD-free MULW, op1=0x1_0000_0003, op2=5 -> res_o=15 after 33 cycles.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide, RV corner cases.
// Latency: N+1 cycles from accept to result (N = 64, or 32 for W ops); 1 cycle for divide-by-zero/overflow.
// Backpressure: result held in DONE until res_ready_i; stall_o freezes upstream while busy; flush_i aborts.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   mdu_info_i[9:0]   {REMU,REM,DIVU,DIV,MULHU,MULHSU,MULH,MUL,WOP,VALID}
//   op1_i, op2_i      rs1 / rs2 operand values
//   flush_i           kills the in-flight operation
//   res_ready_i       downstream accepts the result
//   stall_o           holds IF/ID/EX while the unit is occupied
//   res_valid_o/res_o result handshake and value
module mdu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  mdu_info_i,
    input  logic [63:0] op1_i,
    input  logic [63:0] op2_i,
    input  logic        flush_i,
    input  logic        res_ready_i,
    output logic        stall_o,
    output logic        res_valid_o,
    output logic [63:0] res_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [7:0]     op_q,    op_d;     // {remu,rem,divu,div,mulhu,mulhsu,mulh,mul}
    logic           wop_q,   wop_d;
    logic           sgn_q,   sgn_d;    // product / quotient sign
    logic           rsgn_q,  rsgn_d;   // remainder sign (follows dividend)
    logic [6:0]     cnt_q,   cnt_d;
    logic [127:0]   acc_q,   acc_d;    // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
    logic [63:0]    opnd_q,  opnd_d;   // mul: multiplicand magnitude; div: divisor magnitude
    logic [63:0]    res_q,   res_d;

    // ------------------------------------------------------------------
    // Input decode and operand preparation (only meaningful in IDLE)
    // ------------------------------------------------------------------
    logic        in_vld;
    logic        in_wop;
    logic        in_mul;
    logic        in_div;
    logic        in_quo;       // DIV/DIVU select the quotient
    logic        op1_signed;
    logic        op2_signed;
    logic        ext_signed;   // W ops: DIVUW/REMUW zero-extend, everything else sign-extends
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic        s1;
    logic        s2;
    logic [63:0] mag_a;
    logic [63:0] mag_b;
    logic        div_zero;
    logic        div_ovf;
    logic [63:0] sp_res;
    logic [63:0] sp_fmt;

    always_comb begin
        in_vld     = mdu_info_i[0];
        in_wop     = mdu_info_i[1];
        in_mul     = |mdu_info_i[5:2];
        in_div     = |mdu_info_i[9:6];
        in_quo     = mdu_info_i[6] | mdu_info_i[7];
        op1_signed = mdu_info_i[2] | mdu_info_i[3] | mdu_info_i[4] | mdu_info_i[6] | mdu_info_i[8];
        op2_signed = mdu_info_i[2] | mdu_info_i[3] | mdu_info_i[6] | mdu_info_i[8];
        ext_signed = ~(mdu_info_i[7] | mdu_info_i[9]);

        if (in_wop) begin
            a_ext = ext_signed ? {{32{op1_i[31]}}, op1_i[31:0]} : {32'b0, op1_i[31:0]};
            b_ext = ext_signed ? {{32{op2_i[31]}}, op2_i[31:0]} : {32'b0, op2_i[31:0]};
        end else begin
            a_ext = op1_i;
            b_ext = op2_i;
        end

        s1    = op1_signed & a_ext[63];
        s2    = op2_signed & b_ext[63];
        // The most negative value negates to 2^63, which still fits unsigned.
        mag_a = s1 ? (64'd0 - a_ext) : a_ext;
        mag_b = s2 ? (64'd0 - b_ext) : b_ext;

        div_zero = in_div & (b_ext == 64'd0);
        // a_ext is already sign-extended for W ops, so the 32-bit minimum shows up as 0xFFFFFFFF80000000.
        div_ovf  = (mdu_info_i[6] | mdu_info_i[8])
                 & (in_wop ? (a_ext == 64'hFFFF_FFFF_8000_0000) : (a_ext == 64'h8000_0000_0000_0000))
                 & (b_ext == 64'hFFFF_FFFF_FFFF_FFFF);

        if (div_zero) begin
            sp_res = in_quo ? 64'hFFFF_FFFF_FFFF_FFFF : a_ext;
        end else begin
            sp_res = in_quo ? a_ext : 64'd0;
        end
        sp_fmt = in_wop ? {{32{sp_res[31]}}, sp_res[31:0]} : sp_res;
    end

    // ------------------------------------------------------------------
    // One iteration step and final result formatting
    // ------------------------------------------------------------------
    logic [64:0]  mul_sum;
    logic [127:0] mul_nxt;
    logic [64:0]  div_sh;
    logic [63:0]  div_diff;
    logic [127:0] div_nxt;
    logic [127:0] acc_step;
    logic [127:0] prod;
    logic [127:0] prod_s;
    logic [63:0]  quo_s;
    logic [63:0]  rem_s;
    logic [63:0]  raw_res;
    logic [63:0]  fin_res;

    always_comb begin
        // Shift-add: add the multiplicand into the high half when the current
        // multiplier bit (acc[0]) is set, then shift the whole pair right.
        mul_sum = {1'b0, acc_q[127:64]} + (acc_q[0] ? {1'b0, opnd_q} : 65'd0);
        mul_nxt = {mul_sum, acc_q[63:1]};

        // Restoring divide: shift {rem, quo} left, subtract when it fits.
        div_sh   = {acc_q[127:64], acc_q[63]};
        div_diff = div_sh[63:0] - opnd_q;
        if (div_sh >= {1'b0, opnd_q}) begin
            div_nxt = {div_diff, acc_q[62:0], 1'b1};
        end else begin
            div_nxt = {div_sh[63:0], acc_q[62:0], 1'b0};
        end

        acc_step = (|op_q[3:0]) ? mul_nxt : div_nxt;

        // After 32 iterations the product sits 32 bits above its final position.
        prod   = wop_q ? {32'b0, acc_step[127:32]} : acc_step;
        prod_s = sgn_q ? (128'd0 - prod) : prod;
        quo_s  = sgn_q ? (64'd0 - acc_step[63:0]) : acc_step[63:0];
        rem_s  = rsgn_q ? (64'd0 - acc_step[127:64]) : acc_step[127:64];

        if (op_q[0]) begin
            raw_res = prod_s[63:0];
        end else if (|op_q[3:1]) begin
            raw_res = prod_s[127:64];
        end else if (|op_q[5:4]) begin
            raw_res = quo_s;
        end else if (|op_q[7:6]) begin
            raw_res = rem_s;
        end else begin
            raw_res = 64'd0;
        end
        fin_res = wop_q ? {{32{raw_res[31]}}, raw_res[31:0]} : raw_res;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wop_d   = wop_q;
        sgn_d   = sgn_q;
        rsgn_d  = rsgn_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        res_d   = res_q;

        unique case (state_q)
            IDLE: begin
                if (in_vld && !flush_i) begin
                    op_d   = mdu_info_i[9:2];
                    wop_d  = in_wop;
                    sgn_d  = s1 ^ s2;
                    rsgn_d = s1;
                    if (div_zero || div_ovf) begin
                        res_d   = sp_fmt;
                        state_d = DONE;
                    end else begin
                        cnt_d   = in_wop ? 7'd32 : 7'd64;
                        state_d = CALC;
                        if (in_mul) begin
                            acc_d  = {64'd0, mag_b};
                            opnd_d = mag_a;
                        end else begin
                            // W dividends are pre-aligned to the top so 32 steps consume them.
                            acc_d  = {64'd0, in_wop ? {mag_a[31:0], 32'd0} : mag_a};
                            opnd_d = mag_b;
                        end
                    end
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - 7'd1;
                    if (cnt_q == 7'd1) begin
                        res_d   = fin_res;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (flush_i || res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 8'd0;
            wop_q   <= 1'b0;
            sgn_q   <= 1'b0;
            rsgn_q  <= 1'b0;
            cnt_q   <= 7'd0;
            acc_q   <= 128'd0;
            opnd_q  <= 64'd0;
            res_q   <= 64'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wop_q   <= wop_d;
            sgn_q   <= sgn_d;
            rsgn_q  <= rsgn_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign res_valid_o = (state_q == DONE);
    assign res_o       = res_q;
    assign stall_o     = ((state_q == IDLE) & in_vld & ~flush_i)
                       | (state_q == CALC)
                       | ((state_q == DONE) & ~res_ready_i);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed vectors push expected result and latency,
// an independent monitor pops and compares on every result handshake.
// Also covers reset state, result hold under backpressure, flush and mid-op reset.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  mdu_info_i;
    logic [63:0] op1_i;
    logic [63:0] op2_i;
    logic        flush_i;
    logic        res_ready_i;
    logic        stall_o;
    logic        res_valid_o;
    logic [63:0] res_o;

    mdu_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mdu_info_i  (mdu_info_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .flush_i     (flush_i),
        .res_ready_i (res_ready_i),
        .stall_o     (stall_o),
        .res_valid_o (res_valid_o),
        .res_o       (res_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [9:0] I_MUL    = 10'h005;
    localparam logic [9:0] I_MULH   = 10'h009;
    localparam logic [9:0] I_MULHSU = 10'h011;
    localparam logic [9:0] I_MULHU  = 10'h021;
    localparam logic [9:0] I_DIV    = 10'h041;
    localparam logic [9:0] I_DIVU   = 10'h081;
    localparam logic [9:0] I_REM    = 10'h101;
    localparam logic [9:0] I_REMU   = 10'h201;
    localparam logic [9:0] W        = 10'h002;
    localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc_cyc;
        int          id;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: samples shortly after the falling edge, i.e. the values the DUT
    // sees at the next rising edge.
    initial begin
        logic pv;
        int   fv;
        exp_t e;
        pv = 1'b0;
        fv = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n !== 1'b1) begin
                pv = 1'b0;
            end else begin
                if (res_valid_o && !pv) fv = cyc;
                pv = res_valid_o;
                if (res_valid_o && res_ready_i && !flush_i) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_result: got %h, expected no result", res_o);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("res#%0d", e.id), res_o, e.res);
                        chk($sformatf("lat#%0d", e.id), 64'(fv - e.acc_cyc + 1), 64'(e.lat));
                    end
                end
            end
        end
    end

    // mode 0: wait a falling edge, then present (DUT idle).
    // mode 1: present now, accepted on the next rising edge.
    // mode 2: present now while the previous result is handed off; accepted one edge later.
    task automatic run(input int id, input logic [9:0] info, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int lat,
                       input int hold, input int mode);
        int t;
        if (mode == 0) @(negedge clk);
        mdu_info_i = info;
        op1_i      = a;
        op2_i      = b;
        if (hold > 0) res_ready_i = 1'b0;
        sb.push_back('{res: exp, lat: lat, acc_cyc: cyc + ((mode == 2) ? 2 : 1), id: id});
        repeat ((mode == 2) ? 2 : 1) @(negedge clk);
        // Inputs after acceptance must not influence the running operation.
        mdu_info_i = 10'($urandom) & 10'h3FE;
        op1_i      = {$urandom, $urandom};
        op2_i      = {$urandom, $urandom};
        t = 0;
        while (!res_valid_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!res_valid_o) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout#%0d: got no res_valid_o, expected one within 200 cycles", id);
        end else if (hold > 0) begin
            repeat (hold) begin
                chk($sformatf("hold_res#%0d", id), res_o, exp);
                chk($sformatf("hold_stall#%0d", id), 64'(stall_o), 64'd1);
                @(negedge clk);
            end
            res_ready_i = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        mdu_info_i  = 10'd0;
        op1_i       = 64'd0;
        op2_i       = 64'd0;
        flush_i     = 1'b0;
        res_ready_i = 1'b1;

        // Reset state and input-only stall
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(res_valid_o), 64'd0);
        chk("rst_res", res_o, 64'd0);
        chk("rst_stall_idle", 64'(stall_o), 64'd0);
        mdu_info_i = I_MUL;
        #1 chk("rst_stall_vld", 64'(stall_o), 64'd1);
        flush_i = 1'b1;
        #1 chk("rst_stall_flush", 64'(stall_o), 64'd0);
        flush_i    = 1'b0;
        mdu_info_i = 10'd0;

        // First accept on the first edge after reset release
        @(negedge clk);
        rst_n = 1'b1;
        run(1,  I_MUL,      64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0, 1);
        // Presented during DONE->IDLE: accepted one edge later
        run(2,  I_DIV | W,  64'h0000_0000_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 1, 0, 2);
        run(3,  I_REM | W,  64'h0000_0000_8000_0000, ONES, 64'd0, 1, 0, 0);
        run(4,  I_DIVU,     64'd100, 64'd0, ONES, 1, 0, 0);
        run(5,  I_REM,      64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1, 0, 0);
        run(6,  I_REM,      64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65, 0, 0);
        run(7,  I_DIV,      64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0, 0);
        run(8,  I_MULHU,    ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65, 5, 0);
        run(9,  I_MULH,     ONES, ONES, 64'd0, 65, 0, 0);
        run(10, I_MULHSU,   ONES, ONES, ONES, 65, 0, 0);
        run(11, I_DIV,      64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 1, 0, 0);
        run(12, I_REM,      64'h8000_0000_0000_0000, ONES, 64'd0, 1, 0, 0);
        run(13, I_DIVU | W, 64'h0000_0000_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33, 0, 0);
        run(14, I_REMU | W, 64'd7, 64'd3, 64'd1, 33, 0, 0);
        run(15, I_DIV | W,  64'd5, 64'h0000_0001_0000_0000, ONES, 1, 0, 0);
        run(16, I_REM | W,  64'h0000_0001_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1, 0, 0);
        run(17, I_MUL | W,  64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0, 0);
        run(18, I_DIVU,     64'd1000, 64'd7, 64'd142, 65, 0, 0);
        run(19, I_REMU,     64'd1000, 64'd7, 64'd6, 65, 0, 0);
        run(20, I_DIV,      64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 65, 0, 0);
        run(21, I_REM,      64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 0, 0);
        run(22, I_MUL | W,  64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 33, 0, 0);

        // Flush at CALC cycle 10: back to IDLE, no result ever appears
        @(negedge clk);
        @(negedge clk);
        mdu_info_i = I_MUL;
        op1_i      = 64'd3;
        op2_i      = 64'd4;
        @(negedge clk);
        mdu_info_i = 10'd0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        chk("flush_valid", 64'(res_valid_o), 64'd0);
        chk("flush_stall", 64'(stall_o), 64'd0);
        repeat (70) @(negedge clk);
        chk("flush_no_result", 64'(res_valid_o), 64'd0);

        // Asynchronous reset in the middle of a divide
        mdu_info_i = I_DIV;
        op1_i      = 64'd100;
        op2_i      = 64'd7;
        @(negedge clk);
        mdu_info_i = 10'd0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(res_valid_o), 64'd0);
        chk("arst_res", res_o, 64'd0);
        chk("arst_stall", 64'(stall_o), 64'd0);
        mdu_info_i = I_DIV;
        #1 chk("arst_stall_vld", 64'(stall_o), 64'd1);
        mdu_info_i = 10'd0;
        @(negedge clk);
        rst_n = 1'b1;
        run(23, I_MUL | W,  64'h0000_0001_0000_0003, 64'd5, 64'd15, 33, 0, 1);

        repeat (5) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
